// File: rtl/eth_phy_10g_link_ctrl.sv
// eth_phy_10g_link_ctrl
//   Link bring-up / retrain sequencer for the 10G PHY receive path (rx_clk domain).
//   Sequence: IDLE -> RESET (SERDES RX reset pulse) -> WAIT_LOCK -> WAIT_STATUS -> LINK_UP.
//   Lock and status waits are each bounded by a timeout that forces a retrain.
//   A live link that loses block lock or status falls back to WAIT_LOCK.
//   A SERDES reset request from the PHY forces a retrain from any waiting/up state.
//
// Ports
//   rx_clk, rx_rst_n     clock, asynchronous active-low reset
//   enable               1 = run the sequencer, 0 = hold in IDLE
//   clr_stats            single-cycle clear of retrain_count and err_accum
//   rx_block_lock        PHY block lock
//   rx_status            PHY link-OK status
//   serdes_rx_reset_req  PHY request for a SERDES reset
//   rx_error_count       errors reported by the PHY this cycle
//   serdes_rx_reset      SERDES RX reset drive (high throughout RESET)
//   link_up              high only in LINK_UP
//   state                current FSM encoding (IDLE=0 .. LINK_UP=4)
//   retrain_count        retrains since last clear, saturating at 255
//   err_accum            saturating sum of rx_error_count while in LINK_UP
//   timeout_event        one-cycle pulse when a lock or status wait times out
//
// Handshake: there is no valid/ready traffic here; every input is a level that
// is sampled on each rx_clk edge, and every output is a flop.

module eth_phy_10g_link_ctrl #(
   parameter int RESET_CYCLES   = 16,
   parameter int LOCK_TIMEOUT   = 1024,
   parameter int STATUS_TIMEOUT = 4096,
   parameter int TIMER_WIDTH    = 16,
   parameter int ERR_WIDTH      = 7,
   parameter int ACC_WIDTH      = 16
) (
   input  logic                 rx_clk,
   input  logic                 rx_rst_n,
   input  logic                 enable,
   input  logic                 clr_stats,
   input  logic                 rx_block_lock,
   input  logic                 rx_status,
   input  logic                 serdes_rx_reset_req,
   input  logic [ERR_WIDTH-1:0] rx_error_count,
   output logic                 serdes_rx_reset,
   output logic                 link_up,
   output logic [2:0]           state,
   output logic [7:0]           retrain_count,
   output logic [ACC_WIDTH-1:0] err_accum,
   output logic                 timeout_event
);

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_RESET       = 3'd1,
      ST_WAIT_LOCK   = 3'd2,
      ST_WAIT_STATUS = 3'd3,
      ST_LINK_UP     = 3'd4
   } state_t;

   // Timer reload values: a load of N-1 counted down to 0 gives exactly N cycles.
   localparam logic [TIMER_WIDTH-1:0] RESET_LOAD  = TIMER_WIDTH'(RESET_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] LOCK_LOAD   = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
   localparam logic [TIMER_WIDTH-1:0] STATUS_LOAD = TIMER_WIDTH'(STATUS_TIMEOUT - 1);

   state_t                 state_q, state_n;
   logic [TIMER_WIDTH-1:0] timer_q, timer_n;
   logic                   retrain_inc;
   logic                   timeout_n;
   logic                   err_add;
   logic [ACC_WIDTH:0]     err_sum;

   // Next-state / timer logic. enable=0 overrides everything and touches no stats.
   always_comb begin
      state_n     = state_q;
      timer_n     = timer_q;
      retrain_inc = 1'b0;
      timeout_n   = 1'b0;
      err_add     = 1'b0;
      if (!enable) begin
         state_n = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_n = ST_RESET;
               timer_n = RESET_LOAD;
            end
            ST_RESET: begin
               // serdes_rx_reset_req is deliberately ignored while already in reset.
               if (timer_q == '0) begin
                  state_n = ST_WAIT_LOCK;
                  timer_n = LOCK_LOAD;
               end else begin
                  timer_n = timer_q - TIMER_WIDTH'(1);
               end
            end
            ST_WAIT_LOCK: begin
               if (serdes_rx_reset_req) begin
                  state_n     = ST_RESET;
                  timer_n     = RESET_LOAD;
                  retrain_inc = 1'b1;
               end else if (rx_block_lock) begin
                  state_n = ST_WAIT_STATUS;
                  timer_n = STATUS_LOAD;
               end else if (timer_q == '0) begin
                  state_n     = ST_RESET;
                  timer_n     = RESET_LOAD;
                  retrain_inc = 1'b1;
                  timeout_n   = 1'b1;
               end else begin
                  timer_n = timer_q - TIMER_WIDTH'(1);
               end
            end
            ST_WAIT_STATUS: begin
               if (serdes_rx_reset_req) begin
                  state_n     = ST_RESET;
                  timer_n     = RESET_LOAD;
                  retrain_inc = 1'b1;
               end else if (!rx_block_lock) begin
                  state_n = ST_WAIT_LOCK;
                  timer_n = LOCK_LOAD;
               end else if (rx_status) begin
                  state_n = ST_LINK_UP;
               end else if (timer_q == '0) begin
                  state_n     = ST_RESET;
                  timer_n     = RESET_LOAD;
                  retrain_inc = 1'b1;
                  timeout_n   = 1'b1;
               end else begin
                  timer_n = timer_q - TIMER_WIDTH'(1);
               end
            end
            ST_LINK_UP: begin
               // The error sample of the cycle in which the link drops still counts.
               err_add = 1'b1;
               if (serdes_rx_reset_req) begin
                  state_n     = ST_RESET;
                  timer_n     = RESET_LOAD;
                  retrain_inc = 1'b1;
               end else if (!rx_block_lock || !rx_status) begin
                  state_n = ST_WAIT_LOCK;
                  timer_n = LOCK_LOAD;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // One extra bit catches the carry for saturation.
   assign err_sum = {1'b0, err_accum} + (ACC_WIDTH + 1)'(rx_error_count);

   // State, timer and registered Moore outputs (decoded from the next state so
   // they line up with the state register).
   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         state_q         <= ST_IDLE;
         timer_q         <= '0;
         serdes_rx_reset <= 1'b0;
         link_up         <= 1'b0;
         timeout_event   <= 1'b0;
      end else begin
         state_q         <= state_n;
         timer_q         <= timer_n;
         serdes_rx_reset <= (state_n == ST_RESET);
         link_up         <= (state_n == ST_LINK_UP);
         timeout_event   <= timeout_n;
      end
   end

   // Statistics: clear beats a simultaneous increment.
   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         retrain_count <= '0;
         err_accum     <= '0;
      end else if (clr_stats) begin
         retrain_count <= '0;
         err_accum     <= '0;
      end else begin
         if (retrain_inc && (retrain_count != 8'hFF))
            retrain_count <= retrain_count + 8'd1;
         if (err_add)
            err_accum <= err_sum[ACC_WIDTH] ? '1 : err_sum[ACC_WIDTH-1:0];
      end
   end

   assign state = state_q;

endmodule
